transpose_stream_ctrl: RTL
==========================

# transpose_stream_ctrl

Streaming front-end for the combinational matrix transpose in the attention datapath. Accepts a ROW_IN x COL_IN matrix one row per beat over a valid/ready handshake and stores it in an internal matrix buffer. Once the matrix is complete, it emits the COL_IN x ROW_IN transposed matrix one row per beat, for example feeding K^T rows into the score multiplier. Single buffer: fill and drain phases alternate and never overlap.

## Interface
- DATA_WIDTH, 16, width of one matrix element
- ROW_IN, 8, rows of the input matrix (= columns of output)
- COL_IN, 4, columns of the input matrix (= rows of output)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept an input row
- in_row  in  DATA_WIDTH*COL_IN  input row; element c at bits [DATA_WIDTH*(c+1)-1 : DATA_WIDTH*c]
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts output row
- out_row  out  DATA_WIDTH*ROW_IN  transposed row; element j at bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j]
- out_last  out  1  high with the final output row (index COL_IN-1) of a matrix
- frame_done  out  1  one-cycle pulse after the final output row is accepted

## Operation
- States: FILL, DRAIN. Reset state is FILL.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, in_row is written to buffer row wr_cnt, and wr_cnt increments.
  - On the accept with wr_cnt==ROW_IN-1: wr_cnt resets to 0 and the next state is DRAIN.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_row = row rd_cnt of the transposed buffer. Element j = buffer(row j, column rd_cnt).
  - On out_valid&&out_ready, rd_cnt increments.
  - On the accept with rd_cnt==COL_IN-1: rd_cnt resets to 0, frame_done pulses the next cycle, and the next state is FILL.
- out_last = DRAIN && rd_cnt==COL_IN-1.
- Buffer layout: element (r,c) at flat index r*COL_IN+c. Transposed output element (i,j) comes from flat index j*COL_IN+i.
- Counter widths: wr_cnt uses $clog2(ROW_IN), rd_cnt uses $clog2(COL_IN), each with a minimum of 1 bit. Counters never exceed their limits; wrap is explicit, not by overflow.
- Element data is passed bit-exact. No arithmetic on element values.
- The buffer is not cleared between matrices. Every element is overwritten before it is read.

## Timing
- Reset values: state=FILL, wr_cnt=0, rd_cnt=0, in_ready=1, out_valid=0, out_last=0, frame_done=0, out_row=0 (buffer reset to 0).
- in_ready, out_valid and out_last are decoded from registered state only. They have no combinational path from in_valid or out_ready.
- Latency: the first output row is valid in the cycle after the last input row is accepted.
- Throughput: one row per cycle in each phase. One matrix takes ROW_IN+COL_IN cycles with no backpressure.
- Backpressure: while out_valid=1 && out_ready=0, out_row, out_last and rd_cnt hold stable.
- in_valid asserted during DRAIN is ignored (in_ready=0) and must not corrupt the buffer.
- frame_done is high exactly the cycle after the final output accept. It coincides with in_ready=1 of the next FILL.
- Reset asserted mid-fill or mid-drain aborts immediately and asynchronously to the reset state. The partial matrix is discarded. After release, the next accepted row is row 0.

## Structure
- Shared package: element-index helper functions (flat index r*COL_IN+c), a state enumeration constant (FILL=0, DRAIN=1), and the counter-width computation.
- Sub-module: reuse the existing Transpose (DATA_WIDTH, ROW_IN, COL_IN) on the packed buffer. An rd_cnt-indexed mux then selects one output row from Transpose.out.
- Everything else (FSM, counters, buffer write enables) lives in transpose_stream_ctrl.

## Test plan
Defaults throughout; input element (r,c) = 16*r + c.
- **Nominal:** stream 8 rows with out_ready=1. Expect 4 output rows, the first 1 cycle after the 8th accept. Row i element j = 16*j + i (row 1 = {0x71,...,0x11,0x01}). out_last on row 3, then frame_done.
- **Backpressure:** drop out_ready for 3 cycles on output row 2. Expect out_row and out_last stable throughout and no row skipped or duplicated.
- **Input gaps and DRAIN-phase input:** toggle in_valid randomly during FILL, then assert in_valid with row 0xFFFF... during DRAIN. Expect the output identical to nominal.
- **Back-to-back matrices:** send matrix A, then B (element = 0x100 + 16*r + c) immediately after frame_done. Expect B's transposed output with no residue from A.
- **Reset mid-operation:** assert rst_n=0 after 5 input rows, then release and send a full matrix. Expect the reset values at once, then the correct transpose of the new matrix only.

Source files
------------

// File: rtl/transpose_stream_ctrl_pkg.sv
// Shared definitions for the streaming transpose front-end: phase encoding,
// flat element indexing and counter sizing.
package transpose_stream_ctrl_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Element (r,c) of a matrix with `cols` columns sits at flat index r*cols+c.
  function automatic int unsigned flat_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned cols);
    return r * cols + c;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/transpose_stream_ctrl_transpose.sv
// Combinational transpose of a packed ROW_IN x COL_IN matrix into a packed
// COL_IN x ROW_IN matrix; pure wiring, data passed bit-exact.
module Transpose
  import transpose_stream_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_IN     = 8,
  parameter int unsigned COL_IN     = 4
) (
  input  logic [DATA_WIDTH*ROW_IN*COL_IN-1:0] in,
  output logic [DATA_WIDTH*ROW_IN*COL_IN-1:0] out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < COL_IN; i++) begin
      for (int unsigned j = 0; j < ROW_IN; j++) begin
        out[flat_idx(i, j, ROW_IN)*DATA_WIDTH +: DATA_WIDTH] =
          in[flat_idx(j, i, COL_IN)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Streaming front-end: fills a single matrix buffer one row per beat, then
// drains the transposed matrix one row per beat. Fill and drain never overlap.
module transpose_stream_ctrl
  import transpose_stream_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_IN     = 8,
  parameter int unsigned COL_IN     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*COL_IN-1:0] in_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*ROW_IN-1:0] out_row,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int unsigned WR_W         = cnt_width(ROW_IN);
  localparam int unsigned RD_W         = cnt_width(COL_IN);
  localparam int unsigned ROW_BITS_IN  = DATA_WIDTH * COL_IN;
  localparam int unsigned ROW_BITS_OUT = DATA_WIDTH * ROW_IN;
  localparam int unsigned MAT_BITS     = DATA_WIDTH * ROW_IN * COL_IN;

  state_t              r_state;
  state_t              w_next_state;
  logic [WR_W-1:0]     r_wr_cnt;
  logic [RD_W-1:0]     r_rd_cnt;
  logic                r_frame_done;
  logic [MAT_BITS-1:0] r_buf;
  logic [MAT_BITS-1:0] w_tmat;
  logic                w_in_acc;
  logic                w_out_acc;
  logic                w_wr_last;
  logic                w_rd_last;

  assign w_wr_last = (r_wr_cnt == WR_W'(ROW_IN - 1));
  assign w_rd_last = (r_rd_cnt == RD_W'(COL_IN - 1));
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake outputs depend on r_state and counters only, never on in_valid/out_ready.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    unique case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && w_wr_last) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = w_rd_last;
        if (out_ready && w_rd_last) begin
          w_next_state = FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_out_acc && w_rd_last;
      if (w_in_acc) begin
        r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
      end
      if (w_out_acc) begin
        r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else begin
      for (int unsigned r = 0; r < ROW_IN; r++) begin
        if (w_in_acc && (r_wr_cnt == WR_W'(r))) begin
          r_buf[r*ROW_BITS_IN +: ROW_BITS_IN] <= in_row;
        end
      end
    end
  end

  Transpose #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROW_IN    (ROW_IN),
    .COL_IN    (COL_IN)
  ) u_transpose (
    .in (r_buf),
    .out(w_tmat)
  );

  always_comb begin
    out_row = '0;
    for (int unsigned c = 0; c < COL_IN; c++) begin
      if (r_rd_cnt == RD_W'(c)) begin
        out_row = w_tmat[c*ROW_BITS_OUT +: ROW_BITS_OUT];
      end
    end
  end

  assign frame_done = r_frame_done;

endmodule
